// File: rtl/cpu_core.sv
// Multi-cycle 16-bit register CPU: 16 GPRs, internal program/data memory, I/O-port bus.
// Latency: 3 cycles (NOP/JMP/BZ), 4 (ALU/LDI/LDH), 5 (LOAD/STORE/IN/OUT); HALT parks until reset.
// Backpressure: none; the port block must answer reads combinationally in the PORT cycle.
//
// Ports:
//   clk       single clock, posedge
//   do_reset  synchronous active-high reset (memory contents are preserved)
//   portaddr  port address, driven only while portget/portset high, else 0
//   portval   port write data, driven only while portset high, else 0
//   portget   one-cycle read strobe; portout is captured at the end of that cycle
//   portset   one-cycle write strobe
//   portout   port read data from the port block
//   state     current FSM state encoding
//   opcode    IR[15:12] of the instruction in flight
//
// The memory image is supplied through MEM_INIT (word i at bits [i*WORD_SIZE +: WORD_SIZE])
// and becomes the power-up contents of the memory; reset never reloads it.
module cpu_core #(
    parameter int WORD_SIZE = 16,
    parameter int MEM_WORDS = 256,
    parameter logic [MEM_WORDS*WORD_SIZE-1:0] MEM_INIT = '0
) (
    input  logic                 clk,
    input  logic                 do_reset,
    output logic [WORD_SIZE-1:0] portaddr,
    output logic [WORD_SIZE-1:0] portval,
    output logic                 portget,
    output logic                 portset,
    input  logic [WORD_SIZE-1:0] portout,
    output logic [2:0]           state,
    output logic [3:0]           opcode
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_PORT   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                           OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_SHR = 4'h7,
                           OP_LD  = 4'h8, OP_ST  = 4'h9, OP_JMP = 4'hA, OP_BZ  = 4'hB,
                           OP_IN  = 4'hC, OP_OUT = 4'hD, OP_LDH = 4'hE, OP_HLT = 4'hF;

    state_t                               r_state;
    state_t                               w_next;
    logic [WORD_SIZE-1:0]                 r_pc;
    logic [WORD_SIZE-1:0]                 r_ir;
    logic [WORD_SIZE-1:0]                 r_regs [16];
    logic [WORD_SIZE-1:0]                 r_a;     // R[ra] latched in DECODE
    logic [WORD_SIZE-1:0]                 r_b;     // R[rb]
    logic [WORD_SIZE-1:0]                 r_d;     // R[rd]
    logic [WORD_SIZE-1:0]                 r_res;   // value committed to rd in WRITEBACK
    logic [MEM_WORDS-1:0][WORD_SIZE-1:0]  r_mem = MEM_INIT;

    logic [3:0]           w_op;
    logic [3:0]           w_rd;
    logic [3:0]           w_ra;
    logic [3:0]           w_rb;
    logic [7:0]           w_imm8;
    logic [WORD_SIZE-1:0] w_alu;
    logic [AW-1:0]        w_maddr;
    logic                 w_port_act;

    assign w_op    = r_ir[15:12];
    assign w_rd    = r_ir[11:8];
    assign w_ra    = r_ir[7:4];
    assign w_rb    = r_ir[3:0];
    assign w_imm8  = r_ir[7:0];
    assign w_maddr = r_a[AW-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (do_reset) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_NOP, OP_JMP, OP_BZ: w_next = S_FETCH;
                    OP_LD, OP_ST:          w_next = S_MEM;
                    OP_IN, OP_OUT:         w_next = S_PORT;
                    OP_HLT:                w_next = S_HALT;
                    default:               w_next = S_WB;
                endcase
            end
            S_MEM:    w_next = S_WB;
            S_PORT:   w_next = S_WB;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Result for register-writing ops that finish in EXECUTE
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_LDI: w_alu = {{(WORD_SIZE-8){1'b0}}, w_imm8};
            OP_ADD: w_alu = r_a + r_b;
            OP_SUB: w_alu = r_a - r_b;
            OP_AND: w_alu = r_a & r_b;
            OP_OR:  w_alu = r_a | r_b;
            OP_XOR: w_alu = r_a ^ r_b;
            OP_SHR: w_alu = r_a >> r_b[3:0];
            OP_LDH: begin
                w_alu       = r_d;
                w_alu[15:8] = w_imm8;
            end
            default: w_alu = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (do_reset) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_d   <= '0;
            r_res <= '0;
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir <= r_mem[r_pc[AW-1:0]];
                    r_pc <= r_pc + 1'b1;
                end
                S_DECODE: begin
                    r_a <= r_regs[w_ra];
                    r_b <= r_regs[w_rb];
                    r_d <= r_regs[w_rd];
                end
                S_EXEC: begin
                    r_res <= w_alu;
                    if (w_op == OP_JMP || (w_op == OP_BZ && r_d == '0)) r_pc <= r_a;
                end
                S_MEM:  if (w_op == OP_LD) r_res <= r_mem[w_maddr];
                S_PORT: if (w_op == OP_IN) r_res <= portout;
                S_WB:   if (w_op != OP_ST && w_op != OP_OUT) r_regs[w_rd] <= r_res;
                default: ;
            endcase
        end
    end

    // Memory write port; kept free of reset so reset leaves contents intact
    always_ff @(posedge clk) begin
        if (!do_reset && r_state == S_MEM && w_op == OP_ST) r_mem[w_maddr] <= r_d;
    end

    // Strobes are gated by do_reset so a reset landing on the PORT cycle issues nothing
    assign w_port_act = (r_state == S_PORT) && !do_reset;
    assign portget    = w_port_act && (w_op == OP_IN);
    assign portset    = w_port_act && (w_op == OP_OUT);
    assign portaddr   = (portget || portset) ? r_a : '0;
    assign portval    = portset ? r_d : '0;
    assign state      = r_state;
    assign opcode     = w_op;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: scoreboard of expected port transactions.
// Latency: n/a.
// Backpressure: n/a; portout is held at a constant value.
module tb_cpu_core;
    localparam int W  = 16;
    localparam int MW = 256;
    localparam int NP = 35;

    // Test program (see expected port events in push_run)
    localparam logic [15:0] PROG [NP] = '{
        16'h1105, // 0  LDI r1,5
        16'h1203, // 1  LDI r2,3
        16'h2312, // 2  ADD r3=r1+r2 = 8
        16'hD310, // 3  OUT port[r1]=r3
        16'hC400, // 4  IN  r4=port[r0]
        16'hD400, // 5  OUT port[r0]=r4
        16'h1501, // 6  LDI r5,1
        16'h3605, // 7  SUB r6=r0-r5 = FFFF
        16'hD650, // 8  OUT
        16'h17CD, // 9  LDI r7,CD
        16'hE7AB, // 10 LDH r7 -> ABCD
        16'hD750, // 11 OUT
        16'h1800, // 12 LDI r8,0
        16'hE880, // 13 LDH r8 -> 8000
        16'h190F, // 14 LDI r9,15
        16'h7A89, // 15 SHR r10=r8>>r9 = 0001
        16'hDA50, // 16 OUT
        16'h6B76, // 17 XOR r11=r7^r6 = 5432
        16'hDB50, // 18 OUT
        16'h5C83, // 19 OR  r12=r8|r3 = 8008
        16'hDC50, // 20 OUT
        16'h4D72, // 21 AND r13=r7&r2 = 0001
        16'hDD50, // 22 OUT
        16'h97B0, // 23 STORE mem[r11 mod 256 = 0x32]=r7
        16'h8EB0, // 24 LOAD r14=mem[r11]
        16'hDE50, // 25 OUT
        16'h1103, // 26 LDI r1,3
        16'h1201, // 27 LDI r2,1
        16'h1C22, // 28 LDI r12,34 (exit)
        16'h1D1E, // 29 LDI r13,30 (loop)
        16'hB1C0, // 30 BZ r1 -> r12
        16'hD150, // 31 OUT port[r5]=r1
        16'h3112, // 32 SUB r1=r1-r2
        16'hA0D0, // 33 JMP r13
        16'hF000  // 34 HALT
    };

    function automatic logic [MW*W-1:0] build_prog();
        logic [MW*W-1:0] img;
        img = '0;
        for (int i = 0; i < NP; i++) img[i*W +: W] = PROG[i];
        return img;
    endfunction

    localparam logic [MW*W-1:0] IMG = build_prog();

    logic          clk;
    logic          do_reset;
    logic [W-1:0]  portaddr;
    logic [W-1:0]  portval;
    logic          portget;
    logic          portset;
    logic [W-1:0]  portout;
    logic [2:0]    state;
    logic [3:0]    opcode;

    cpu_core #(.WORD_SIZE(W), .MEM_WORDS(MW), .MEM_INIT(IMG)) dut (
        .clk      (clk),
        .do_reset (do_reset),
        .portaddr (portaddr),
        .portval  (portval),
        .portget  (portget),
        .portset  (portset),
        .portout  (portout),
        .state    (state),
        .opcode   (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          set;
        logic [W-1:0]  addr;
        logic [W-1:0]  val;
    } ev_t;

    ev_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic set, input logic [W-1:0] addr, input logic [W-1:0] val);
        ev_t e;
        e.set  = set;
        e.addr = addr;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Expected port traffic of one complete program run (portout held at 0x1234)
    task automatic push_run();
        push_ev(1'b1, 16'd5, 16'h0008);
        push_ev(1'b0, 16'd0, 16'h0000);
        push_ev(1'b1, 16'd0, 16'h1234);
        push_ev(1'b1, 16'd1, 16'hFFFF);
        push_ev(1'b1, 16'd1, 16'hABCD);
        push_ev(1'b1, 16'd1, 16'h0001);
        push_ev(1'b1, 16'd1, 16'h5432);
        push_ev(1'b1, 16'd1, 16'h8008);
        push_ev(1'b1, 16'd1, 16'h0001);
        push_ev(1'b1, 16'd1, 16'hABCD);
        push_ev(1'b1, 16'd1, 16'h0003);
        push_ev(1'b1, 16'd1, 16'h0002);
        push_ev(1'b1, 16'd1, 16'h0001);
    endtask

    // Port monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (portget || portset) begin
            chk("strobe_excl", {31'd0, portget & portset}, 32'd0);
            chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                ev_t e;
                e = sb.pop_front();
                chk("port_kind", {31'd0, portset}, {31'd0, e.set});
                chk("port_addr", {16'd0, portaddr}, {16'd0, e.addr});
                chk("port_val",  {16'd0, portval},  {16'd0, e.val});
            end
        end else begin
            chk("idle_bus", {portaddr, portval}, 32'd0);
        end
    end

    task automatic wait_halt(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (state == 3'd6) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic [2:0] exp_st [4];
        bit         found;
        exp_st[0] = 3'd1; exp_st[1] = 3'd2; exp_st[2] = 3'd5; exp_st[3] = 3'd0;

        do_reset = 1'b1;
        portout  = 16'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state",  {29'd0, state}, 32'd0);
        chk("rst_opcode", {28'd0, opcode}, 32'd0);
        chk("rst_get",    {31'd0, portget}, 32'd0);
        chk("rst_set",    {31'd0, portset}, 32'd0);

        // Run 1: full program
        push_run();
        do_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ldi_state_seq", {29'd0, state}, {29'd0, exp_st[i]});
            if (i == 0) begin
                chk("first_opcode", {28'd0, opcode}, 32'd1);
                chk("first_ir", {16'd0, dut.r_ir}, 32'h1105);
            end
        end
        wait_halt("halt_reached");
        chk("sb_empty_run1", sb.size(), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_hold", {29'd0, state}, 32'd6);
        end
        chk("halt_opcode", {28'd0, opcode}, 32'd15);

        // Run 2: reset landing on the PORT cycle of the first OUT
        do_reset = 1'b1;
        repeat (2) @(negedge clk);
        do_reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (state == 3'd4) found = 1'b1;
        end
        chk("reach_port", {31'd0, found}, 32'd1);
        do_reset = 1'b1;
        #1;
        chk("abort_set", {31'd0, portset}, 32'd0);
        chk("abort_addr", {16'd0, portaddr}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_pc", {16'd0, dut.r_pc}, 32'd0);
        chk("abort_opcode", {28'd0, opcode}, 32'd0);

        // Run 3: program restarts from address 0 and repeats its traffic
        @(negedge clk);
        push_run();
        do_reset = 1'b0;
        wait_halt("halt_reached2");
        chk("sb_empty_run3", sb.size(), 32'd0);
        repeat (5) @(negedge clk);
        chk("halt_hold2", {29'd0, state}, 32'd6);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
